// File: rtl/alu_writeback_pkg.sv
// ----------------------------------------------------------------------------
// alu_writeback_pkg
//   Shared definitions for the ALU writeback stage: datapath and register-index
//   widths, and the packed pipeline-entry record held between the ALU and the
//   register file / flag register commit.
//   Optional feature macro used by the stage: WB_BYPASS_EN (operand forwarding).
// ----------------------------------------------------------------------------
package alu_writeback_pkg;

    localparam int WB_W   = 8;
    localparam int REG_AW = 3;
    localparam int REG_N  = 1 << REG_AW;

    typedef struct packed {
        logic [WB_W-1:0]   result;
        logic              zero;
        logic              par;
        logic [REG_AW-1:0] dest;
        logic              reg_we;
        logic              flag_we;
    } wb_entry_t;

    function automatic wb_entry_t wb_entry_empty();
        wb_entry_t e;
        e = '0;
        return e;
    endfunction

endpackage

// File: rtl/alu_writeback_reg_file.sv
// ----------------------------------------------------------------------------
// alu_writeback_reg_file
//   NREG x W architectural register file: one synchronous write port, two
//   asynchronous read ports. Asynchronous active-low reset clears every entry.
//   Reads during a write return the value held before the edge.
// Ports
//   clk       in   clock, writes on rising edge
//   rst_n     in   asynchronous active-low reset
//   we        in   write enable
//   waddr     in   write index
//   wdata     in   write data
//   raddr_a/b in   read indices
//   rdata_a/b out  read data (combinational)
// ----------------------------------------------------------------------------
module alu_writeback_reg_file #(
    parameter int W    = 8,
    parameter int NREG = 8,
    parameter int AW   = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr_a,
    input  logic [AW-1:0] raddr_b,
    output logic [W-1:0]  rdata_a,
    output logic [W-1:0]  rdata_b
);

    logic [W-1:0] mem [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/alu_writeback.sv
// ----------------------------------------------------------------------------
// alu_writeback
//   Writeback stage behind the combinational ALU. A single-entry pipeline
//   register captures the ALU result and ZER0/PAR0 flags, then commits them to
//   the register file and flag register. The one RF write port is shared with
//   the data-memory load path under a fairness bit that alternates on
//   contention. Two asynchronous read ports feed the ALU operand muxes.
//   Macro WB_BYPASS_EN: when defined, read ports forward the pending entry,
//   then a granted load, ahead of the RF. When undefined, reads see the
//   committed RF only.
// Ports
//   Clk, Reset_n               clock / asynchronous active-low reset
//   ex_valid/ex_ready          ALU result handshake
//   ex_result/zero/par         ALU result and flags
//   ex_dest/reg_we/flag_we     destination and write enables
//   ld_valid/ld_data/ld_dest   load write request
//   ld_ready                   load owns the RF write port this cycle
//   rd_addr_a/b, rd_data_a/b   operand read ports
//   zero_flag, par_flag        committed flags
// ----------------------------------------------------------------------------
module alu_writeback
    import alu_writeback_pkg::*;
#(
    parameter int W    = WB_W,
    parameter int NREG = REG_N,
    parameter int AW   = REG_AW
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          ex_valid,
    output logic          ex_ready,
    input  logic [W-1:0]  ex_result,
    input  logic          ex_zero,
    input  logic          ex_par,
    input  logic [AW-1:0] ex_dest,
    input  logic          ex_reg_we,
    input  logic          ex_flag_we,
    input  logic          ld_valid,
    input  logic [W-1:0]  ld_data,
    input  logic [AW-1:0] ld_dest,
    output logic          ld_ready,
    input  logic [AW-1:0] rd_addr_a,
    input  logic [AW-1:0] rd_addr_b,
    output logic [W-1:0]  rd_data_a,
    output logic [W-1:0]  rd_data_b,
    output logic          zero_flag,
    output logic          par_flag
);

    // Every index must address a real register, and the entry record is
    // built from the package widths.
    if (NREG != (1 << AW)) begin : g_bad_nreg
        $error("alu_writeback: NREG must equal 2**AW");
    end
    if ((W != WB_W) || (AW != REG_AW)) begin : g_bad_width
        $error("alu_writeback: W/AW must match alu_writeback_pkg widths");
    end

    wb_entry_t     wb_q;
    logic          wb_valid;
    logic          last_ld;

    logic          wb_req;
    logic          contended;
    logic          wb_grant;
    logic          ld_grant;
    logic          wb_commit;
    logic          ex_xfer;

    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [W-1:0]  rf_wdata;
    logic [W-1:0]  rf_rdata_a;
    logic [W-1:0]  rf_rdata_b;

    // Write-port arbitration. last_ld remembers who won the previous
    // contended cycle so the loser goes first next time.
    always_comb begin
        wb_req    = wb_valid && wb_q.reg_we;
        contended = wb_req && ld_valid;
        wb_grant  = 1'b0;
        ld_grant  = 1'b0;
        if (contended) begin
            ld_grant = !last_ld;
            wb_grant = last_ld;
        end else begin
            wb_grant = wb_req;
            ld_grant = ld_valid;
        end
    end

    // An entry without an RF write retires without needing the port.
    assign wb_commit = wb_valid && (!wb_q.reg_we || wb_grant);
    assign ex_ready  = !wb_valid || wb_commit;
    assign ex_xfer   = ex_valid && ex_ready;
    assign ld_ready  = ld_grant;

    assign rf_we    = wb_grant || ld_grant;
    assign rf_waddr = wb_grant ? wb_q.dest   : ld_dest;
    assign rf_wdata = wb_grant ? wb_q.result : ld_data;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wb_q      <= wb_entry_empty();
            wb_valid  <= 1'b0;
            last_ld   <= 1'b0;
            zero_flag <= 1'b0;
            par_flag  <= 1'b0;
        end else begin
            if (contended) begin
                last_ld <= ld_grant;
            end
            if (wb_commit && wb_q.flag_we) begin
                zero_flag <= wb_q.zero;
                par_flag  <= wb_q.par;
            end
            // A retiring entry and a new transfer on the same edge keep the
            // stage full, giving one result per cycle.
            if (ex_xfer) begin
                wb_valid     <= 1'b1;
                wb_q.result  <= ex_result;
                wb_q.zero    <= ex_zero;
                wb_q.par     <= ex_par;
                wb_q.dest    <= ex_dest;
                wb_q.reg_we  <= ex_reg_we;
                wb_q.flag_we <= ex_flag_we;
            end else if (wb_commit) begin
                wb_valid <= 1'b0;
            end
        end
    end

    alu_writeback_reg_file #(
        .W    (W),
        .NREG (NREG),
        .AW   (AW)
    ) u_reg_file (
        .clk     (Clk),
        .rst_n   (Reset_n),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata),
        .raddr_a (rd_addr_a),
        .raddr_b (rd_addr_b),
        .rdata_a (rf_rdata_a),
        .rdata_b (rf_rdata_b)
    );

`ifdef WB_BYPASS_EN
    // Youngest value wins: the pending entry is newer than any load that is
    // writing this cycle, which is newer than the RF contents.
    always_comb begin
        rd_data_a = rf_rdata_a;
        if (wb_req && (wb_q.dest == rd_addr_a)) begin
            rd_data_a = wb_q.result;
        end else if (ld_grant && (ld_dest == rd_addr_a)) begin
            rd_data_a = ld_data;
        end
    end

    always_comb begin
        rd_data_b = rf_rdata_b;
        if (wb_req && (wb_q.dest == rd_addr_b)) begin
            rd_data_b = wb_q.result;
        end else if (ld_grant && (ld_dest == rd_addr_b)) begin
            rd_data_b = ld_data;
        end
    end
`else
    assign rd_data_a = rf_rdata_a;
    assign rd_data_b = rf_rdata_b;
`endif

endmodule

// File: tb/tb_alu_writeback.sv
`timescale 1ns/1ps
module tb_alu_writeback;

`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       ex_valid;
    logic       ex_ready;
    logic [7:0] ex_result;
    logic       ex_zero;
    logic       ex_par;
    logic [2:0] ex_dest;
    logic       ex_reg_we;
    logic       ex_flag_we;
    logic       ld_valid;
    logic [7:0] ld_data;
    logic [2:0] ld_dest;
    logic       ld_ready;
    logic [2:0] rd_addr_a;
    logic [2:0] rd_addr_b;
    logic [7:0] rd_data_a;
    logic [7:0] rd_data_b;
    logic       zero_flag;
    logic       par_flag;

    int n_vec = 0;
    int n_err = 0;

    alu_writeback dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .ex_valid   (ex_valid),
        .ex_ready   (ex_ready),
        .ex_result  (ex_result),
        .ex_zero    (ex_zero),
        .ex_par     (ex_par),
        .ex_dest    (ex_dest),
        .ex_reg_we  (ex_reg_we),
        .ex_flag_we (ex_flag_we),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_dest    (ld_dest),
        .ld_ready   (ld_ready),
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .rd_data_a  (rd_data_a),
        .rd_data_b  (rd_data_b),
        .zero_flag  (zero_flag),
        .par_flag   (par_flag)
    );

    always #10 Clk = ~Clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_rd(input string tag, input logic [2:0] addr, input logic [7:0] exp);
        rd_addr_a = addr;
        rd_addr_b = addr;
        #1;
        check_val({tag, "_a"}, {24'd0, rd_data_a}, {24'd0, exp});
        check_val({tag, "_b"}, {24'd0, rd_data_b}, {24'd0, exp});
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive_ex(input logic [2:0] dest, input logic [7:0] res, input logic reg_we,
                            input logic flag_we, input logic z, input logic p);
        ex_valid   = 1'b1;
        ex_dest    = dest;
        ex_result  = res;
        ex_reg_we  = reg_we;
        ex_flag_we = flag_we;
        ex_zero    = z;
        ex_par     = p;
    endtask

    task automatic clr_ex();
        ex_valid   = 1'b0;
        ex_dest    = '0;
        ex_result  = '0;
        ex_reg_we  = 1'b0;
        ex_flag_we = 1'b0;
        ex_zero    = 1'b0;
        ex_par     = 1'b0;
    endtask

    task automatic drive_ld(input logic v, input logic [2:0] dest, input logic [7:0] data);
        ld_valid = v;
        ld_dest  = dest;
        ld_data  = data;
    endtask

    initial begin
        Reset_n = 1'b0;
        clr_ex();
        drive_ld(1'b0, 3'd0, 8'h00);
        rd_addr_a = '0;
        rd_addr_b = '0;

        // 1: reset state
        #25;
        for (int i = 0; i < 8; i++) begin
            check_rd("rst_rf", 3'(i), 8'h00);
        end
        check_val("rst_zero", {31'd0, zero_flag}, 32'd0);
        check_val("rst_par", {31'd0, par_flag}, 32'd0);
        check_val("rst_ex_ready", {31'd0, ex_ready}, 32'd1);
        check_val("rst_ld_ready", {31'd0, ld_ready}, 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;

        // 2: single result, commit one edge after transfer
        step();
        drive_ex(3'd3, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        check_val("t2_ex_ready", {31'd0, ex_ready}, 32'd1);
        step();
        clr_ex();
        step();
        check_rd("t2_r3", 3'd3, 8'hA5);
        check_val("t2_zero", {31'd0, zero_flag}, 32'd0);
        check_val("t2_par", {31'd0, par_flag}, 32'd0);

        // 3: back-to-back results r1, r2, r3
        drive_ex(3'd1, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        check_val("t3_rdy0", {31'd0, ex_ready}, 32'd1);
        step();
        drive_ex(3'd2, 8'h20, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        check_val("t3_rdy1", {31'd0, ex_ready}, 32'd1);
        step();
        drive_ex(3'd3, 8'h30, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        check_val("t3_rdy2", {31'd0, ex_ready}, 32'd1);
        check_rd("t3_r1", 3'd1, 8'h10);
        check_rd("t3_r2_pend", 3'd2, BYP ? 8'h20 : 8'h00);
        step();
        clr_ex();
        check_rd("t3_r2", 3'd2, 8'h20);
        check_rd("t3_r3_pend", 3'd3, BYP ? 8'h30 : 8'hA5);
        step();
        check_rd("t3_r3", 3'd3, 8'h30);

        // 4: pending wb r2 contends with load r4 for two cycles
        drive_ex(3'd2, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        clr_ex();
        drive_ld(1'b1, 3'd4, 8'h22);
        #1;
        check_val("t4_c1_ld_ready", {31'd0, ld_ready}, 32'd1);
        check_val("t4_c1_ex_ready", {31'd0, ex_ready}, 32'd0);
        step();
        #1;
        check_val("t4_c2_ld_ready", {31'd0, ld_ready}, 32'd0);
        check_val("t4_c2_ex_ready", {31'd0, ex_ready}, 32'd1);
        step();
        drive_ld(1'b0, 3'd0, 8'h00);
        check_rd("t4_r4", 3'd4, 8'h22);
        check_rd("t4_r2", 3'd2, 8'h11);

        // 5: flag-only entry retires alongside a granted load
        drive_ex(3'd6, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b1);
        step();
        clr_ex();
        drive_ld(1'b1, 3'd5, 8'h77);
        #1;
        check_val("t5_ld_ready", {31'd0, ld_ready}, 32'd1);
        check_val("t5_ex_ready", {31'd0, ex_ready}, 32'd1);
        step();
        drive_ld(1'b0, 3'd0, 8'h00);
        check_val("t5_zero", {31'd0, zero_flag}, 32'd1);
        check_val("t5_par", {31'd0, par_flag}, 32'd1);
        check_rd("t5_r5", 3'd5, 8'h77);
        check_rd("t5_r6", 3'd6, 8'h00);

        // 6: read of a pending entry, then of a granted load
        drive_ex(3'd5, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        clr_ex();
        check_rd("t6_r5_pend", 3'd5, BYP ? 8'h3C : 8'h77);
        step();
        check_rd("t6_r5", 3'd5, 8'h3C);
        check_val("t6_zero_hold", {31'd0, zero_flag}, 32'd1);
        check_val("t6_par_hold", {31'd0, par_flag}, 32'd1);
        drive_ld(1'b1, 3'd7, 8'h5A);
        #1;
        check_val("t6_ld_ready", {31'd0, ld_ready}, 32'd1);
        check_rd("t6_r7_ld", 3'd7, BYP ? 8'h5A : 8'h00);
        step();
        drive_ld(1'b0, 3'd0, 8'h00);
        check_rd("t6_r7", 3'd7, 8'h5A);

        // 7: reset while an entry is pending
        drive_ex(3'd0, 8'hEE, 1'b1, 1'b1, 1'b0, 1'b1);
        step();
        clr_ex();
        #1;
        Reset_n = 1'b0;
        #1;
        check_rd("t7_rst_r0", 3'd0, 8'h00);
        check_rd("t7_rst_r5", 3'd5, 8'h00);
        check_val("t7_rst_zero", {31'd0, zero_flag}, 32'd0);
        check_val("t7_rst_par", {31'd0, par_flag}, 32'd0);
        step();
        step();
        @(negedge Clk);
        Reset_n = 1'b1;
        step();
        step();
        check_rd("t7_r0", 3'd0, 8'h00);
        check_val("t7_ex_ready", {31'd0, ex_ready}, 32'd1);
        check_val("t7_par", {31'd0, par_flag}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
